// File: rtl/mcp_host_if.sv
// Host-side initiator for the 8-bit MCP register bus: writes A/B/op, waits, reads back X.
// Define MCP_HOST_POLL_EN to replace the fixed compute wait with status polling (address 7) and a timeout flag.
module mcp_host_if #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int WAIT_CYCLES   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [7:0]  cmd_op,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_x,
  output logic        busy,
`ifdef MCP_HOST_POLL_EN
  output logic        timeout,
`endif
  output logic        readBus,
  output logic        writeBus,
  output logic [2:0]  addressBus,
  inout  wire  [7:0]  dataBus
);
  typedef enum logic [3:0] {IDLE, WSETUP, WSTROBE, WHOLD, WAIT, RSETUP, RSTROBE, RHOLD, DONE} state_t;

  localparam int CMAX = 4*WAIT_CYCLES + SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] C_SET = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] C_STB = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] C_HLD = CW'(HOLD_CYCLES - 1);
`ifdef MCP_HOST_POLL_EN
  localparam logic [CW-1:0] C_TMO = CW'(4*WAIT_CYCLES - 1);
`else
  localparam logic [CW-1:0] C_WAIT = CW'(WAIT_CYCLES - 1);
`endif

  state_t        r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [2:0]    r_idx, w_nidx;
  logic [15:0]   r_a, r_b, w_a, w_b;
  logic [7:0]    r_op, w_op;
  logic [31:0]   r_x;
  logic          r_rd_n, r_wr_n, r_oe, r_valid, r_ready, r_busy;
  logic [2:0]    r_addr, w_naddr;
  logic [7:0]    r_dout, w_ndout;
  logic          w_accept, w_sample, w_wr_ph, w_rd_ph;
`ifdef MCP_HOST_POLL_EN
  logic          r_poll, w_npoll, r_stat, r_timeout, w_tmo;
  logic [CW-1:0] r_tcnt;
`endif

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt + 1'b1;
    w_nidx   = r_idx;
    w_accept = 1'b0;
    w_sample = 1'b0;
`ifdef MCP_HOST_POLL_EN
    w_npoll  = r_poll;
    w_tmo    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_ncnt = '0;
        if (cmd_valid && r_ready) begin
          w_accept = 1'b1;
          w_nidx   = '0;
          w_nstate = WSETUP;
        end
      end
      WSETUP:  if (r_cnt == C_SET) begin w_ncnt = '0; w_nstate = WSTROBE; end
      WSTROBE: if (r_cnt == C_STB) begin w_ncnt = '0; w_nstate = WHOLD; end
      WHOLD: if (r_cnt == C_HLD) begin
        w_ncnt = '0;
        if (r_idx == 3'd4) begin
          w_nidx = '0;
`ifdef MCP_HOST_POLL_EN
          w_nstate = RSETUP;
          w_npoll  = 1'b1;
`else
          w_nstate = WAIT;
`endif
        end else begin
          w_nidx   = r_idx + 3'd1;
          w_nstate = WSETUP;
        end
      end
`ifndef MCP_HOST_POLL_EN
      WAIT: if (r_cnt == C_WAIT) begin w_ncnt = '0; w_nstate = RSETUP; end
`endif
      RSETUP:  if (r_cnt == C_SET) begin w_ncnt = '0; w_nstate = RSTROBE; end
      RSTROBE: if (r_cnt == C_STB) begin w_ncnt = '0; w_sample = 1'b1; w_nstate = RHOLD; end
      RHOLD: if (r_cnt == C_HLD) begin
        w_ncnt   = '0;
        w_nstate = RSETUP;
`ifdef MCP_HOST_POLL_EN
        // Timeout is only honoured at the end of a status read so no bus cycle is cut short.
        if (r_poll) begin
          if (!r_stat || r_tcnt >= C_TMO) begin
            w_npoll = 1'b0;
            w_tmo   = r_stat;
          end
        end else
`endif
        if (r_idx == 3'd3) w_nstate = DONE;
        else               w_nidx   = r_idx + 3'd1;
      end
      DONE: begin
        w_ncnt = '0;
        if (res_ready) w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  // Bus outputs are computed from the next state so every pin comes straight off a flop.
  always_comb begin
    w_a     = w_accept ? cmd_a  : r_a;
    w_b     = w_accept ? cmd_b  : r_b;
    w_op    = w_accept ? cmd_op : r_op;
    w_wr_ph = (w_nstate == WSETUP) || (w_nstate == WSTROBE) || (w_nstate == WHOLD);
    w_rd_ph = (w_nstate == RSETUP) || (w_nstate == RSTROBE) || (w_nstate == RHOLD);
    w_naddr = r_addr;
    if (w_wr_ph)      w_naddr = (w_nidx == 3'd4) ? 3'd7 : w_nidx;
    else if (w_rd_ph) w_naddr = w_nidx;
`ifdef MCP_HOST_POLL_EN
    if (w_rd_ph && w_npoll) w_naddr = 3'd7;
`endif
    case (w_nidx)
      3'd0:    w_ndout = w_a[15:8];
      3'd1:    w_ndout = w_a[7:0];
      3'd2:    w_ndout = w_b[15:8];
      3'd3:    w_ndout = w_b[7:0];
      default: w_ndout = w_op;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_x     <= '0;
      r_rd_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_oe    <= 1'b0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
`ifdef MCP_HOST_POLL_EN
      r_poll    <= 1'b0;
      r_stat    <= 1'b0;
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_idx   <= w_nidx;
      r_wr_n  <= (w_nstate != WSTROBE);
      r_rd_n  <= (w_nstate != RSTROBE);
      r_oe    <= w_wr_ph;
      r_addr  <= w_naddr;
      r_dout  <= w_ndout;
      r_valid <= (w_nstate == DONE);
      r_ready <= (w_nstate == IDLE);
      r_busy  <= (w_nstate != IDLE);
      if (w_accept) begin
        r_a  <= cmd_a;
        r_b  <= cmd_b;
        r_op <= cmd_op;
      end
      if (w_sample) begin
`ifdef MCP_HOST_POLL_EN
        if (r_poll) r_stat <= dataBus[0];
        else
`endif
        case (r_idx[1:0])
          2'd0:    r_x[31:24] <= dataBus;
          2'd1:    r_x[23:16] <= dataBus;
          2'd2:    r_x[15:8]  <= dataBus;
          default: r_x[7:0]   <= dataBus;
        endcase
      end
`ifdef MCP_HOST_POLL_EN
      r_poll <= w_npoll;
      r_tcnt <= r_poll ? r_tcnt + 1'b1 : '0;
      if (w_accept)   r_timeout <= 1'b0;
      else if (w_tmo) r_timeout <= 1'b1;
`endif
    end
  end

  assign cmd_ready  = r_ready;
  assign busy       = r_busy;
  assign res_valid  = r_valid;
  assign res_x      = r_x;
  assign readBus    = r_rd_n;
  assign writeBus   = r_wr_n;
  assign addressBus = r_addr;
  assign dataBus    = r_oe ? r_dout : 8'bz;
`ifdef MCP_HOST_POLL_EN
  assign timeout    = r_timeout;
`endif
endmodule
